// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: loads a program byte stream into instruction memory,
// then walks the PC with branch/stall handling and halts on address faults.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        loadValid,
  input  logic        loadLast,
  input  logic [31:0] loadAddr,
  input  logic [7:0]  loadData,
  output logic        loadReady,
  output logic [31:0] instructionAddress,
  output logic        fetchValid,
  output logic        memWriteEnable,
  output logic [31:0] memWriteAddress,
  output logic [7:0]  memWriteData,
  output logic [1:0]  state,
  output logic        fault,
  output logic [31:0] fetchCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  // 33-bit compares so MEM_BYTES up to 2^32 and PC+4 carry never alias.
  localparam logic [32:0] MEM_SIZE  = 33'(MEM_BYTES);
  localparam logic [32:0] MEM_LAST  = MEM_SIZE - 33'd4;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc;
  logic [32:0] pc_inc;
  logic        accept;
  logic        load_oob;
  logic        branch_bad;
  logic        seq_bad;
  logic        run_fault;
  logic        restart;

  // Handshake: a loader byte transfers on a rising edge where loadValid && loadReady.
  assign accept     = loadValid && loadReady;
  assign load_oob   = {1'b0, loadAddr} >= MEM_SIZE;
  assign pc_inc     = {1'b0, pc} + 33'd4;
  assign branch_bad = (branchTarget[1:0] != 2'b00) || ({1'b0, branchTarget} >= MEM_SIZE);
  assign seq_bad    = pc_inc > MEM_LAST;
  assign run_fault  = (state_q == RUN) && (branchTaken ? branch_bad : (!stall && seq_bad));
  assign restart    = start && (((state_q == IDLE) && !accept) || (state_q == HALT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)     state_d = LOAD;
        else if (start) state_d = RUN;
      end
      LOAD: if (accept && loadLast) state_d = IDLE;
      RUN:  if (run_fault) state_d = HALT;
      HALT: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    loadReady  = 1'b0;
    fetchValid = 1'b0;
    case (state_q)
      IDLE, LOAD: loadReady  = 1'b1;
      RUN:        fetchValid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      fault      <= 1'b0;
      fetchCount <= 32'd0;
    end else begin
      if (restart) begin
        pc <= RESET_PC;
      end else if ((state_q == RUN) && !run_fault) begin
        if (branchTaken) pc <= branchTarget;
        else if (!stall) pc <= pc_inc[31:0];
      end

      if ((state_q == HALT) && start)          fault <= 1'b0;
      else if ((accept && load_oob) || run_fault) fault <= 1'b1;

      if ((state_q == RUN) && !stall) fetchCount <= fetchCount + 32'd1;
    end
  end

  // Out-of-range loader bytes are consumed but never reach memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memWriteEnable  <= 1'b0;
      memWriteAddress <= 32'd0;
      memWriteData    <= 8'd0;
    end else begin
      memWriteEnable <= accept && !load_oob;
      if (accept && !load_oob) begin
        memWriteAddress <= loadAddr;
        memWriteData    <= loadData;
      end
    end
  end

  assign instructionAddress = pc;
  assign state              = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a vector table for load/run/branch/fault
// flows plus hand sequences for reset abort and load-vs-start arbitration.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        loadValid;
  logic        loadLast;
  logic [31:0] loadAddr;
  logic [7:0]  loadData;
  logic        loadReady;
  logic [31:0] instructionAddress;
  logic        fetchValid;
  logic        memWriteEnable;
  logic [31:0] memWriteAddress;
  logic [7:0]  memWriteData;
  logic [1:0]  state;
  logic        fault;
  logic [31:0] fetchCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        st, sl, br;
    logic [31:0] tg;
    logic        lv, ll;
    logic [31:0] la;
    logic [7:0]  ld;
    logic [1:0]  est;
    logic [31:0] eia;
    logic        efv, erdy, ewe;
    logic [31:0] ewa;
    logic [7:0]  ewd;
    logic        eflt;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  logic [39:0] exp_q[$];

  fetch_controller #(.RESET_PC(32'd0), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .loadValid(loadValid), .loadLast(loadLast), .loadAddr(loadAddr), .loadData(loadData),
    .loadReady(loadReady), .instructionAddress(instructionAddress), .fetchValid(fetchValid),
    .memWriteEnable(memWriteEnable), .memWriteAddress(memWriteAddress), .memWriteData(memWriteData),
    .state(state), .fault(fault), .fetchCount(fetchCount)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, sl, br, input logic [31:0] tg,
                       input logic lv, ll, input logic [31:0] la, input logic [7:0] ld);
    start = st; stall = sl; branchTaken = br; branchTarget = tg;
    loadValid = lv; loadLast = ll; loadAddr = la; loadData = ld;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'd0, 0, 0, 32'd0, 8'd0);
  endtask

  task automatic add(input logic st, sl, br, input logic [31:0] tg,
                     input logic lv, ll, input logic [31:0] la, input logic [7:0] ld,
                     input logic [1:0] est, input logic [31:0] eia,
                     input logic efv, erdy, ewe, input logic [31:0] ewa, input logic [7:0] ewd,
                     input logic eflt, input logic [31:0] ecnt);
    vec_t v;
    v.st = st; v.sl = sl; v.br = br; v.tg = tg; v.lv = lv; v.ll = ll; v.la = la; v.ld = ld;
    v.est = est; v.eia = eia; v.efv = efv; v.erdy = erdy; v.ewe = ewe;
    v.ewa = ewa; v.ewd = ewd; v.eflt = eflt; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, " state"}, {30'd0, state}, {30'd0, v.est});
    chk({tag, " pc"},    instructionAddress, v.eia);
    chk({tag, " fv"},    {31'd0, fetchValid}, {31'd0, v.efv});
    chk({tag, " ready"}, {31'd0, loadReady}, {31'd0, v.erdy});
    chk({tag, " we"},    {31'd0, memWriteEnable}, {31'd0, v.ewe});
    chk({tag, " waddr"}, memWriteAddress, v.ewa);
    chk({tag, " wdata"}, {24'd0, memWriteData}, {24'd0, v.ewd});
    chk({tag, " fault"}, {31'd0, fault}, {31'd0, v.eflt});
    chk({tag, " count"}, fetchCount, v.ecnt);
  endtask

  // Scoreboard: every observed memory write must match the next expected one.
  always @(negedge clk) begin
    if (rst && memWriteEnable) begin
      if (exp_q.size() == 0) begin
        chk("sb unexpected write", memWriteAddress, 32'hFFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("sb write", {memWriteAddress[23:0], memWriteData}, {e[31:8], e[7:0]});
        chk("sb waddr", memWriteAddress, e[39:8]);
      end
    end
  end

  initial begin
    // Vector table: row inputs applied, then outputs compared after the next edge.
    add(0,0,0,32'd0,    1,0,32'd0,8'h00, 2'd1,32'd0,   0,1,1,32'd0,8'h00,0,32'd0);
    add(0,0,0,32'd0,    1,0,32'd1,8'h22, 2'd1,32'd0,   0,1,1,32'd1,8'h22,0,32'd0);
    add(0,0,0,32'd0,    1,0,32'd2,8'h18, 2'd1,32'd0,   0,1,1,32'd2,8'h18,0,32'd0);
    add(0,0,0,32'd0,    1,1,32'd3,8'h21, 2'd0,32'd0,   0,1,1,32'd3,8'h21,0,32'd0);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd0,32'd0,   0,1,0,32'd3,8'h21,0,32'd0);
    add(1,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd0,   1,0,0,32'd3,8'h21,0,32'd0);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd4,   1,0,0,32'd3,8'h21,0,32'd1);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd8,   1,0,0,32'd3,8'h21,0,32'd2);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd12,  1,0,0,32'd3,8'h21,0,32'd3);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd16,  1,0,0,32'd3,8'h21,0,32'd4);
    add(0,1,1,32'd32,   0,0,32'd0,8'h00, 2'd2,32'd32,  1,0,0,32'd3,8'h21,0,32'd4);
    add(0,1,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd32,  1,0,0,32'd3,8'h21,0,32'd4);
    add(0,1,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd32,  1,0,0,32'd3,8'h21,0,32'd4);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd36,  1,0,0,32'd3,8'h21,0,32'd5);
    add(0,1,1,32'd34,   0,0,32'd0,8'h00, 2'd3,32'd36,  0,0,0,32'd3,8'h21,1,32'd5);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd3,32'd36,  0,0,0,32'd3,8'h21,1,32'd5);
    add(1,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd0,   1,0,0,32'd3,8'h21,0,32'd5);
    add(0,1,1,32'd4088, 0,0,32'd0,8'h00, 2'd2,32'd4088,1,0,0,32'd3,8'h21,0,32'd5);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd4092,1,0,0,32'd3,8'h21,0,32'd6);
    add(0,0,0,32'd0,    0,0,32'd0,8'h00, 2'd3,32'd4092,0,0,0,32'd3,8'h21,1,32'd7);
    add(1,0,0,32'd0,    0,0,32'd0,8'h00, 2'd2,32'd0,   1,0,0,32'd3,8'h21,0,32'd7);
    add(0,0,0,32'd0,    1,0,32'd5,8'h99, 2'd2,32'd4,   1,0,0,32'd3,8'h21,0,32'd8);

    exp_q.push_back({32'd0, 8'h00});
    exp_q.push_back({32'd1, 8'h22});
    exp_q.push_back({32'd2, 8'h18});
    exp_q.push_back({32'd3, 8'h21});

    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", {30'd0, state}, 32'd0);
    chk("reset pc", instructionAddress, 32'd0);
    chk("reset ready", {31'd0, loadReady}, 32'd1);
    chk("reset fv", {31'd0, fetchValid}, 32'd0);
    chk("reset we", {31'd0, memWriteEnable}, 32'd0);
    chk("reset waddr", memWriteAddress, 32'd0);
    chk("reset fault", {31'd0, fault}, 32'd0);
    chk("reset count", fetchCount, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].tg,
            vecs[i].lv, vecs[i].ll, vecs[i].la, vecs[i].ld);
      @(posedge clk);
      #1;
      check_row($sformatf("row%0d", i), vecs[i]);
    end
    idle();

    // Reset in the middle of RUN aborts at once.
    rst = 1'b0;
    #1;
    chk("runrst state", {30'd0, state}, 32'd0);
    chk("runrst pc", instructionAddress, 32'd0);
    chk("runrst count", fetchCount, 32'd0);
    chk("runrst fv", {31'd0, fetchValid}, 32'd0);
    chk("runrst ready", {31'd0, loadReady}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Load and start together in IDLE: load wins.
    drive(1, 0, 0, 32'd0, 1, 0, 32'h10, 8'h55);
    exp_q.push_back({32'h10, 8'h55});
    @(posedge clk);
    #1;
    chk("ldstart state", {30'd0, state}, 32'd1);
    chk("ldstart we", {31'd0, memWriteEnable}, 32'd1);
    chk("ldstart fv", {31'd0, fetchValid}, 32'd0);
    // Out-of-range byte: dropped, faults, flow still returns to IDLE.
    drive(0, 0, 0, 32'd0, 1, 1, 32'd4096, 8'h77);
    @(posedge clk);
    #1;
    chk("oob state", {30'd0, state}, 32'd0);
    chk("oob we", {31'd0, memWriteEnable}, 32'd0);
    chk("oob fault", {31'd0, fault}, 32'd1);
    drive(1, 0, 0, 32'd0, 0, 0, 32'd0, 8'd0);
    @(posedge clk);
    #1;
    chk("oob run state", {30'd0, state}, 32'd2);
    chk("oob sticky fault", {31'd0, fault}, 32'd1);
    chk("oob run pc", instructionAddress, 32'd0);
    idle();

    // Reset one cycle after an accepted byte cancels the pending write.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 32'd0, 1, 0, 32'd8, 8'hAA);
    @(posedge clk);
    #1;
    idle();
    chk("ldrst pre state", {30'd0, state}, 32'd1);
    chk("ldrst pre we", {31'd0, memWriteEnable}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ldrst we", {31'd0, memWriteEnable}, 32'd0);
    chk("ldrst state", {30'd0, state}, 32'd0);
    chk("ldrst waddr", memWriteAddress, 32'd0);
    chk("ldrst wdata", {24'd0, memWriteData}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("sb drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
